// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//   Two-read / one-write register file with a per-register pending-write
//   scoreboard and an optional same-cycle write-to-read bypass.
//
//   Decode reads operands and scoreboard state through ra1/ra2 and marks the
//   destination of an issuing instruction via issue/issue_rd.
//   Writeback retires a result through we/wa/wd, which also clears the
//   pending bit of that register.
//
// Parameters
//   XLEN   : data width of each register
//   NREG   : number of architectural registers (power of 2, 2..32)
//   BYPASS : 1 = a write in the current cycle is forwarded to matching reads
//            0 = reads see only state captured at the previous edge
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset (clears data and busy)
//   ra1, ra2  in   read addresses (5 bit; values >= NREG read as x0)
//   rd1, rd2  out  read data (combinational)
//   busy1/2   out  scoreboard bit for ra1/ra2 (combinational)
//   we,wa,wd  in   write port
//   issue     in   mark issue_rd as pending
//   issue_rd  in   destination register of the issuing instruction
//   any_busy  out  OR of all registered scoreboard bits
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic            issue,
  input  logic [4:0]      issue_rd,
  output logic            any_busy
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  // An address is usable only if it is nonzero and inside the implemented
  // range; x0 and out-of-range addresses behave identically (read 0, never
  // busy, writes/issues dropped).
  function automatic logic addr_live(input logic [4:0] addr);
    logic in_range;
    in_range  = ({1'b0, addr} < 6'(NREG));
    addr_live = in_range && (addr != 5'd0);
  endfunction

  // Storage
  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Decoded request qualifiers
  logic          wr_ok_s;
  logic          iss_ok_s;
  logic          rd1_ok_s;
  logic          rd2_ok_s;
  logic [AW-1:0] wa_idx_s;
  logic [AW-1:0] iss_idx_s;
  logic [AW-1:0] ra1_idx_s;
  logic [AW-1:0] ra2_idx_s;

  // Qualify write/issue/read requests against x0 and the implemented range.
  always_comb begin
    wr_ok_s   = we    && addr_live(wa);
    iss_ok_s  = issue && addr_live(issue_rd);
    rd1_ok_s  = addr_live(ra1);
    rd2_ok_s  = addr_live(ra2);
    wa_idx_s  = wa[AW-1:0];
    iss_idx_s = issue_rd[AW-1:0];
    ra1_idx_s = ra1[AW-1:0];
    ra2_idx_s = ra2[AW-1:0];
  end

  // Register array: cleared by reset, written by the retiring instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
      end
    end else if (wr_ok_s) begin
      regs_q[wa_idx_s] <= wd;
    end
  end

  // Scoreboard next state: a write clears, an issue sets; the issue is
  // applied last so a same-register collision leaves the new producer
  // pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok_s) begin
      busy_d[wa_idx_s] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (iss_ok_s) begin
      busy_d[iss_idx_s] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= {NREG{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  // Bypass hits: only a qualified write outside reset may be forwarded, so
  // reset forces the read ports to zero regardless of the write port.
  logic byp1_s;
  logic byp2_s;
  logic iss_hit1_s;
  logic iss_hit2_s;

  // Detect same-cycle write/issue matches for each read port.
  always_comb begin
    byp1_s     = (BYPASS != 0) && !reset && wr_ok_s && (wa == ra1);
    byp2_s     = (BYPASS != 0) && !reset && wr_ok_s && (wa == ra2);
    iss_hit1_s = iss_ok_s && (issue_rd == ra1);
    iss_hit2_s = iss_ok_s && (issue_rd == ra2);
  end

  // Read port 1: zero for dead addresses, forwarded data on a bypass hit,
  // otherwise the stored register.
  always_comb begin
    rd1   = {XLEN{1'b0}};
    busy1 = 1'b0;
    if (!rd1_ok_s) begin
      rd1   = {XLEN{1'b0}};
      busy1 = 1'b0;
    end else if (byp1_s) begin
      rd1   = wd;
      busy1 = iss_hit1_s;
    end else begin
      rd1   = regs_q[ra1_idx_s];
      busy1 = busy_q[ra1_idx_s];
    end
  end

  // Read port 2: same selection as port 1, independent of it.
  always_comb begin
    rd2   = {XLEN{1'b0}};
    busy2 = 1'b0;
    if (!rd2_ok_s) begin
      rd2   = {XLEN{1'b0}};
      busy2 = 1'b0;
    end else if (byp2_s) begin
      rd2   = wd;
      busy2 = iss_hit2_s;
    end else begin
      rd2   = regs_q[ra2_idx_s];
      busy2 = busy_q[ra2_idx_s];
    end
  end

  // Aggregate pending flag from registered state only.
  always_comb begin
    any_busy = |busy_q;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
//   Directed bench for regfile_sb. Three instances:
//     u_byp  : XLEN=32, NREG=32, BYPASS=1
//     u_nob  : XLEN=32, NREG=32, BYPASS=0 (shares inputs with u_byp)
//     u_wide : XLEN=64, NREG=16, BYPASS=1
//   Inputs change 1 ns after a rising edge; outputs are sampled a further
//   1 ns later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

  logic clk;
  logic reset;

  // shared 32-bit stimulus
  logic [4:0]  ra1, ra2, wa, issue_rd;
  logic        we, issue;
  logic [31:0] wd;

  logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
  logic        b_busy1, b_busy2, b_any, n_busy1, n_busy2, n_any;

  // wide instance stimulus
  logic [4:0]  w_ra1, w_ra2, w_wa, w_issue_rd;
  logic        w_we, w_issue;
  logic [63:0] w_wd;
  logic [63:0] w_rd1, w_rd2;
  logic        w_busy1, w_busy2, w_any;

  int checks_s;
  int errors_s;

  regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(b_rd1), .rd2(b_rd2),
    .busy1(b_busy1), .busy2(b_busy2), .we(we), .wa(wa), .wd(wd),
    .issue(issue), .issue_rd(issue_rd), .any_busy(b_any)
  );

  regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) u_nob (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(n_rd1), .rd2(n_rd2),
    .busy1(n_busy1), .busy2(n_busy2), .we(we), .wa(wa), .wd(wd),
    .issue(issue), .issue_rd(issue_rd), .any_busy(n_any)
  );

  regfile_sb #(.XLEN(64), .NREG(16), .BYPASS(1)) u_wide (
    .clk(clk), .reset(reset), .ra1(w_ra1), .ra2(w_ra2), .rd1(w_rd1), .rd2(w_rd2),
    .busy1(w_busy1), .busy2(w_busy2), .we(w_we), .wa(w_wa), .wd(w_wd),
    .issue(w_issue), .issue_rd(w_issue_rd), .any_busy(w_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single comparison point
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_s++;
    if (got !== exp) begin
      errors_s++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one rising edge and step 1 ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; wa = 5'd0; wd = 32'd0; issue = 1'b0; issue_rd = 5'd0;
    w_we = 1'b0; w_wa = 5'd0; w_wd = 64'd0; w_issue = 1'b0; w_issue_rd = 5'd0;
  endtask

  initial begin
    checks_s = 0;
    errors_s = 0;
    reset = 1'b1;
    ra1 = 5'd0; ra2 = 5'd0; w_ra1 = 5'd0; w_ra2 = 5'd0;
    idle_inputs();
    tick();
    tick();
    // ---- reset state
    ra1 = 5'd5; ra2 = 5'd7;
    #1;
    check_eq("rst_rd1", {32'd0, b_rd1}, 64'd0);
    check_eq("rst_busy1", {63'd0, b_busy1}, 64'd0);
    check_eq("rst_any", {63'd0, b_any}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // ---- write x5 and issue x6, then async reset mid-cycle
    tick();
    we = 1'b1; wa = 5'd5; wd = 32'h0000_1234; issue = 1'b1; issue_rd = 5'd6;
    tick();
    idle_inputs();
    #1;
    check_eq("pre_rst_rd1", {32'd0, b_rd1}, 64'h1234);
    check_eq("pre_rst_any", {63'd0, b_any}, 64'd1);
    reset = 1'b1;
    #1;
    check_eq("async_rst_rd1", {32'd0, b_rd1}, 64'd0);
    check_eq("async_rst_any", {63'd0, b_any}, 64'd0);
    check_eq("async_rst_nob_rd1", {32'd0, n_rd1}, 64'd0);
    // writes and issues ignored under reset, including bypass
    we = 1'b1; wa = 5'd5; wd = 32'h0000_0099; issue = 1'b1; issue_rd = 5'd5;
    #1;
    check_eq("rst_no_bypass", {32'd0, b_rd1}, 64'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_write_dropped", {32'd0, b_rd1}, 64'd0);
    check_eq("rst_issue_dropped", {63'd0, b_busy1}, 64'd0);

    // ---- write/read x7
    tick();
    we = 1'b1; wa = 5'd7; wd = 32'hDEAD_BEEF; ra1 = 5'd0; ra2 = 5'd0;
    tick();
    idle_inputs();
    ra1 = 5'd7; ra2 = 5'd7;
    #1;
    check_eq("wr_rd1", {32'd0, b_rd1}, 64'hDEAD_BEEF);
    check_eq("wr_rd2", {32'd0, b_rd2}, 64'hDEAD_BEEF);
    check_eq("wr_nob_rd1", {32'd0, n_rd1}, 64'hDEAD_BEEF);

    // ---- write to x0 (also not forwarded)
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0;
    #1;
    check_eq("x0_bypass", {32'd0, b_rd1}, 64'd0);
    tick();
    idle_inputs();
    #1;
    check_eq("x0_read", {32'd0, b_rd1}, 64'd0);

    // ---- scoreboard: issue x3 at edge N, write at N+2
    issue = 1'b1; issue_rd = 5'd3; ra1 = 5'd3;
    tick();
    idle_inputs();
    #1;
    check_eq("sb_busy1", {63'd0, b_busy1}, 64'd1);
    check_eq("sb_any", {63'd0, b_any}, 64'd1);
    tick();
    #1;
    check_eq("sb_hold", {63'd0, n_busy1}, 64'd1);
    we = 1'b1; wa = 5'd3; wd = 32'h0000_0055;
    tick();
    idle_inputs();
    #1;
    check_eq("sb_clr_busy1", {63'd0, b_busy1}, 64'd0);
    check_eq("sb_clr_rd1", {32'd0, b_rd1}, 64'h55);
    check_eq("sb_clr_any", {63'd0, b_any}, 64'd0);
    // issue to x0 never sets busy
    issue = 1'b1; issue_rd = 5'd0; ra1 = 5'd0;
    tick();
    idle_inputs();
    #1;
    check_eq("sb_x0_busy", {63'd0, b_busy1}, 64'd0);
    check_eq("sb_x0_any", {63'd0, b_any}, 64'd0);

    // ---- bypass: x9 = 0x10, then same-cycle write 0x20
    we = 1'b1; wa = 5'd9; wd = 32'h0000_0010;
    tick();
    we = 1'b1; wa = 5'd9; wd = 32'h0000_0020; ra1 = 5'd9; ra2 = 5'd9;
    #1;
    check_eq("byp_rd2", {32'd0, b_rd2}, 64'h20);
    check_eq("byp_rd1_same", {32'd0, b_rd1}, 64'h20);
    check_eq("byp_busy2", {63'd0, b_busy2}, 64'd0);
    check_eq("nob_rd2_old", {32'd0, n_rd2}, 64'h10);
    tick();
    idle_inputs();
    #1;
    check_eq("nob_rd2_new", {32'd0, n_rd2}, 64'h20);

    // ---- collision on x4 with busy[4]=1
    issue = 1'b1; issue_rd = 5'd4; ra1 = 5'd4;
    tick();
    we = 1'b1; wa = 5'd4; wd = 32'h0000_00AB; issue = 1'b1; issue_rd = 5'd4;
    #1;
    check_eq("col_byp_rd1", {32'd0, b_rd1}, 64'hAB);
    check_eq("col_byp_busy1", {63'd0, b_busy1}, 64'd1);
    check_eq("col_nob_rd1_old", {32'd0, n_rd1}, 64'd0);
    tick();
    idle_inputs();
    #1;
    check_eq("col_rd1", {32'd0, b_rd1}, 64'hAB);
    check_eq("col_busy1", {63'd0, b_busy1}, 64'd1);
    check_eq("col_nob_busy1", {63'd0, n_busy1}, 64'd1);
    // a plain write then clears it; bypass shows busy 0 before the edge
    we = 1'b1; wa = 5'd4; wd = 32'h0000_00CD;
    #1;
    check_eq("col_byp_clr", {63'd0, b_busy1}, 64'd0);
    tick();
    idle_inputs();
    #1;
    check_eq("col_clr_busy1", {63'd0, n_busy1}, 64'd0);
    check_eq("col_clr_rd1", {32'd0, n_rd1}, 64'hCD);

    // ---- wide instance: NREG=16, XLEN=64
    w_we = 1'b1; w_wa = 5'd20; w_wd = 64'hFFFF_0000_FFFF_0000;
    w_issue = 1'b1; w_issue_rd = 5'd20; w_ra1 = 5'd20; w_ra2 = 5'd4;
    #1;
    check_eq("w_oor_bypass", w_rd1, 64'd0);
    tick();
    idle_inputs();
    #1;
    check_eq("w_oor_rd1", w_rd1, 64'd0);
    check_eq("w_oor_busy1", {63'd0, w_busy1}, 64'd0);
    check_eq("w_alias_rd2", w_rd2, 64'd0);
    check_eq("w_oor_any", {63'd0, w_any}, 64'd0);
    w_we = 1'b1; w_wa = 5'd15; w_wd = 64'h0123_4567_89AB_CDEF;
    w_issue = 1'b1; w_issue_rd = 5'd15;
    tick();
    idle_inputs();
    w_ra1 = 5'd15;
    #1;
    check_eq("w_x15_rd1", w_rd1, 64'h0123_4567_89AB_CDEF);
    check_eq("w_x15_busy1", {63'd0, w_busy1}, 64'd1);
    check_eq("w_any", {63'd0, w_any}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks_s, errors_s);
    $finish;
  end

endmodule
